// File: rtl/fractal_sync_pkg.sv
// Shared state encoding, sync request/response payload types and LFSR helpers
// for the fractal sync compute-unit traffic generator.
package fractal_sync_pkg;

  localparam int unsigned SYNC_LVL_W = 2;
  localparam int unsigned SYNC_ID_W  = 4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } port_state_e;

  typedef struct packed {
    logic [SYNC_LVL_W-1:0] level;
    logic [SYNC_ID_W-1:0]  id;
  } sync_req_t;

  typedef struct packed {
    logic [SYNC_LVL_W-1:0] level;
    logic [SYNC_ID_W-1:0]  id;
    logic                  error;
  } sync_rsp_t;

  // Galois form, shifting right; a non-zero seed never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/fractal_sync_cu_tg_port.sv
// One CU sync channel: request -> wait for wake -> gap, repeated n_sync times.
// Request held until req_ready_i; responses have no backpressure and are always consumed.
module fractal_sync_cu_tg_port
  import fractal_sync_pkg::*;
#(
  parameter int unsigned LVL_W    = 2,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TO_W     = 12,
  parameter int unsigned GAP_W    = 4,
  parameter int unsigned RAND_GAP = 0,
  parameter int unsigned PORT_IDX = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_sync_i,
  input  logic [LVL_W-1:0] level_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic [TO_W-1:0]  timeout_i,
  output logic             req_valid_o,
  output logic [LVL_W-1:0] req_level_o,
  output logic [ID_W-1:0]  req_id_o,
  input  logic             req_ready_i,
  input  logic             rsp_valid_i,
  input  logic [LVL_W-1:0] rsp_level_i,
  input  logic [ID_W-1:0]  rsp_id_i,
  input  logic             rsp_error_i,
  output logic [CNT_W-1:0] sync_cnt_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             done_o
);

  port_state_e      state_q;
  logic             req_valid_q;
  logic [LVL_W-1:0] req_level_q;
  logic [ID_W-1:0]  req_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [15:0]      lfsr_q;

  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic [TO_W:0]    to_inc;
  logic             last_sync;
  logic             mismatch;
  logic             to_hit;
  logic [GAP_W-1:0] gap_load;

  assign cnt_inc   = {1'b0, cnt_q} + 1'b1;
  assign cnt_sat   = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
  assign last_sync = (cnt_inc == {1'b0, n_sync_i});
  assign mismatch  = (rsp_level_i != level_i) || (rsp_id_i != id_i);
  // to_cnt_q counts completed WAIT cycles, so the abort fires at the end of
  // the timeout_i-th cycle without a response.
  assign to_inc    = {1'b0, to_cnt_q} + 1'b1;
  assign to_hit    = (timeout_i != '0) && (to_inc == {1'b0, timeout_i});
  assign gap_load  = (RAND_GAP != 0) ? lfsr_q[GAP_W-1:0] : gap_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      req_level_q <= '0;
      req_id_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      lfsr_q      <= LFSR_SEED ^ 16'(PORT_IDX);
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            if (n_sync_i == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q     <= ST_REQ;
              req_valid_q <= 1'b1;
              req_level_q <= level_i;
              req_id_q    <= id_i;
            end
          end
          if (rsp_valid_i) err_q <= 1'b1;
        end
        ST_REQ: begin
          // A wake before or together with acceptance cannot belong to this request.
          if (rsp_valid_i) err_q <= 1'b1;
          if (req_ready_i) begin
            state_q     <= ST_WAIT;
            req_valid_q <= 1'b0;
            req_level_q <= '0;
            req_id_q    <= '0;
            to_cnt_q    <= '0;
          end
        end
        ST_WAIT: begin
          if (rsp_valid_i) begin
            if (mismatch || rsp_error_i) err_q <= 1'b1;
            cnt_q <= cnt_sat;
            if (last_sync) begin
              state_q <= ST_DONE;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_load;
              if (RAND_GAP != 0) lfsr_q <= lfsr_step(lfsr_q);
            end
          end else if (to_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (rsp_valid_i) err_q <= 1'b1;
          if (gap_cnt_q == '0) begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
            req_level_q <= level_i;
            req_id_q    <= id_i;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_level_o = req_level_q;
  assign req_id_o    = req_id_q;
  assign sync_cnt_o  = cnt_q;
  assign err_o       = err_q;
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: rtl/fractal_sync_cu_tg.sv
// N_PORTS-channel barrier traffic generator for the fractal sync tree; config captured on start_i.
// Requests are valid/ready per port; done_o is registered one cycle behind the last port finishing.
module fractal_sync_cu_tg
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS  = 2,
  parameter int unsigned LVL_W    = 2,
  parameter int unsigned ID_W     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TO_W     = 12,
  parameter int unsigned GAP_W    = 4,
  parameter int unsigned RAND_GAP = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         n_sync_i,
  input  logic [N_PORTS*LVL_W-1:0] cfg_level_i,
  input  logic [N_PORTS*ID_W-1:0]  cfg_id_i,
  input  logic [GAP_W-1:0]         cfg_gap_i,
  input  logic [TO_W-1:0]          cfg_timeout_i,
  output logic [N_PORTS-1:0]       req_valid_o,
  output logic [N_PORTS*LVL_W-1:0] req_level_o,
  output logic [N_PORTS*ID_W-1:0]  req_id_o,
  input  logic [N_PORTS-1:0]       req_ready_i,
  input  logic [N_PORTS-1:0]       rsp_valid_i,
  input  logic [N_PORTS*LVL_W-1:0] rsp_level_i,
  input  logic [N_PORTS*ID_W-1:0]  rsp_id_i,
  input  logic [N_PORTS-1:0]       rsp_error_i,
  output logic [N_PORTS*CNT_W-1:0] sync_cnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [N_PORTS-1:0]       err_o
);

  logic [CNT_W-1:0]         n_sync_q;
  logic [N_PORTS*LVL_W-1:0] level_q;
  logic [N_PORTS*ID_W-1:0]  id_q;
  logic [GAP_W-1:0]         gap_q;
  logic [TO_W-1:0]          timeout_q;
  logic                     done_q;

  logic [N_PORTS-1:0]       port_busy;
  logic [N_PORTS-1:0]       port_done;
  logic                     start_go;

  logic [CNT_W-1:0]         n_sync_cur;
  logic [N_PORTS*LVL_W-1:0] level_cur;
  logic [N_PORTS*ID_W-1:0]  id_cur;
  logic [GAP_W-1:0]         gap_cur;
  logic [TO_W-1:0]          timeout_cur;

  assign busy_o   = |port_busy;
  assign start_go = start_i & ~busy_o;

  // Ports act on the start cycle itself, so they see the live config then and
  // the captured copy for the rest of the run.
  assign n_sync_cur  = start_go ? n_sync_i      : n_sync_q;
  assign level_cur   = start_go ? cfg_level_i   : level_q;
  assign id_cur      = start_go ? cfg_id_i      : id_q;
  assign gap_cur     = start_go ? cfg_gap_i     : gap_q;
  assign timeout_cur = start_go ? cfg_timeout_i : timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_sync_q  <= '0;
      level_q   <= '0;
      id_q      <= '0;
      gap_q     <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (start_go) begin
        n_sync_q  <= n_sync_i;
        level_q   <= cfg_level_i;
        id_q      <= cfg_id_i;
        gap_q     <= cfg_gap_i;
        timeout_q <= cfg_timeout_i;
      end
      done_q <= start_go ? 1'b0 : &port_done;
    end
  end

  assign done_o = done_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    fractal_sync_cu_tg_port #(
      .LVL_W    (LVL_W),
      .ID_W     (ID_W),
      .CNT_W    (CNT_W),
      .TO_W     (TO_W),
      .GAP_W    (GAP_W),
      .RAND_GAP (RAND_GAP),
      .PORT_IDX (p)
    ) u_port (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (start_go),
      .n_sync_i    (n_sync_cur),
      .level_i     (level_cur[p*LVL_W +: LVL_W]),
      .id_i        (id_cur[p*ID_W +: ID_W]),
      .gap_i       (gap_cur),
      .timeout_i   (timeout_cur),
      .req_valid_o (req_valid_o[p]),
      .req_level_o (req_level_o[p*LVL_W +: LVL_W]),
      .req_id_o    (req_id_o[p*ID_W +: ID_W]),
      .req_ready_i (req_ready_i[p]),
      .rsp_valid_i (rsp_valid_i[p]),
      .rsp_level_i (rsp_level_i[p*LVL_W +: LVL_W]),
      .rsp_id_i    (rsp_id_i[p*ID_W +: ID_W]),
      .rsp_error_i (rsp_error_i[p]),
      .sync_cnt_o  (sync_cnt_o[p*CNT_W +: CNT_W]),
      .err_o       (err_o[p]),
      .busy_o      (port_busy[p]),
      .done_o      (port_done[p])
    );
  end

endmodule

// File: doc/fractal_sync_cu_tg.md
Name: fractal_sync_cu_tg

Overview:
- Synthesizable, multi-port successor of the compute-unit sync BFM.
- Drives N_PORTS independent compute-unit sync channels into a fractal sync tree: issues barrier requests (level, id), waits for the matching wake/response, then repeats a configured number of times.
- Inserts a fixed or pseudo-random gap between barriers.
- Counts completed barriers and flags timeout, mismatch and error conditions per port.
- Used for on-FPGA/emulation stress of the sync network and as a reusable RTL stimulus in block-level benches.

Parameters:
- N_PORTS, 2, number of independent CU channels.
- LVL_W, 2, width of the barrier level field.
- ID_W, 4, width of the barrier id field.
- CNT_W, 16, width of barrier-count and per-port completion counters.
- TO_W, 12, width of the response timeout counter.
- GAP_W, 4, width of the inter-barrier gap counter.
- RAND_GAP, 0, 0 = gap taken from cfg_gap_i; 1 = gap taken from a per-port 16-bit LFSR (low GAP_W bits).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; starts all ports when idle
- n_sync_i  in  CNT_W  barriers per port; 0 means finish immediately
- cfg_level_i  in  N_PORTS*LVL_W  per-port request level
- cfg_id_i  in  N_PORTS*ID_W  per-port request id
- cfg_gap_i  in  GAP_W  fixed gap in cycles (RAND_GAP=0)
- cfg_timeout_i  in  TO_W  response timeout; 0 disables timeout
- req_valid_o  out  N_PORTS  request valid
- req_level_o  out  N_PORTS*LVL_W  request level
- req_id_o  out  N_PORTS*ID_W  request id
- req_ready_i  in  N_PORTS  request accepted
- rsp_valid_i  in  N_PORTS  response/wake strobe (no ready; always accepted)
- rsp_level_i  in  N_PORTS*LVL_W  response level
- rsp_id_i  in  N_PORTS*ID_W  response id
- rsp_error_i  in  N_PORTS  network reports sync error
- sync_cnt_o  out  N_PORTS*CNT_W  completed barriers per port
- busy_o  out  1  any port not IDLE/DONE
- done_o  out  1  all ports DONE (level, held until next start_i)
- err_o  out  N_PORTS  sticky per-port error (timeout | mismatch | rsp_error)

Behaviour:
- Reset: all FSMs IDLE.
  - req_valid_o = 0, req_level_o/req_id_o = 0, sync_cnt_o = 0.
  - busy_o = 0, done_o = 0, err_o = 0.
  - LFSRs seeded to 16'hACE1 XOR port index (never zero).
- Configuration (cfg_*, n_sync_i) is sampled on start_i and held internally for the whole run.
- Per-port FSM:
  - IDLE: on start_i, clear sync_cnt and err, then go to REQ; if n_sync = 0, go straight to DONE.
  - REQ: req_valid_o = 1 with the sampled level/id. valid stays high and payload stays stable until req_ready_i. Handshake completes in the cycle valid & ready; next state WAIT. Timeout counter is cleared on entry.
  - WAIT: req_valid_o = 0. On rsp_valid_i:
    - mismatch = (rsp_level ≠ sampled level) or (rsp_id ≠ sampled id).
    - Set err if mismatch or rsp_error_i.
    - sync_cnt increments in every case (counter saturates at all-ones).
    - If sync_cnt+1 == n_sync, go to DONE; else go to GAP.
  - WAIT timeout: when timeout ≠ 0 and the counter reaches cfg_timeout, set err and go to DONE (port aborted; sync_cnt not incremented).
  - GAP: load gap (cfg_gap, or LFSR[GAP_W-1:0] with LFSR stepped once per load). Count down to 0, then go to REQ. A gap of 0 goes to REQ on the next cycle (minimum 1 cycle between barriers).
  - DONE: hold until start_i, then restart as from IDLE.
- start_i while busy_o = 1 is ignored.
- rsp_valid_i outside WAIT: ignored for counting, but sets err (spurious wake).
- rsp_valid_i in the same cycle as the REQ handshake: treated as spurious (the response must follow acceptance by at least 1 cycle); sets err.
- done_o = AND over ports of (state == DONE), registered (1-cycle latency after the last port enters DONE).
- busy_o is combinational from states.
- Reset asserted mid-operation: immediate return to reset values; any outstanding request is dropped.

Decomposition:
- fractal_sync_pkg holds:
  - the per-port state enum (IDLE, REQ, WAIT, GAP, DONE);
  - the sync request/response struct typedefs parametrised via LVL_W/ID_W localparams;
  - the LFSR tap constant 16'hB400.
- One sub-module is natural: fractal_sync_cu_tg_port (the single-port FSM, counters and LFSR), instantiated N_PORTS times via generate.
- The top level handles config sampling, done_o and busy_o reduction.

Test Plan:
- Basic: N_PORTS=2, n_sync=3, ready tied 1, response 2 cycles after acceptance with matching level/id -> 3 requests per port, sync_cnt_o=3 each, done_o rises, err_o=0.
- Backpressure: req_ready_i low for 5 cycles -> req_valid_o held with stable level=2/id=5; exactly one handshake counted.
- Mismatch: port1 cfg_id=4, response id=6 -> err_o[1]=1, err_o[0]=0, sync_cnt_o[1] still increments, run completes.
- Timeout: cfg_timeout=8, no response on port0 -> err_o[0]=1 after 8 WAIT cycles, port0 DONE with sync_cnt=0, done_o rises after port1 finishes.
- Gap and restart: cfg_gap=3 -> exactly 4 cycles from response to next req_valid_o. start_i during busy ignored; start_i after done restarts and clears the counters.
- Reset mid-WAIT: rst_ni low -> all outputs zero asynchronously; after release, a new start_i runs cleanly with n_sync=0 -> done_o next cycle plus the 1-cycle register delay.
